// File: rtl/cpu_seq_pkg.sv
// Shared definitions for the instruction sequencer.
//   seq_state_t  : sequencer state encoding
//   PC_WIDTH_DEF : default PC / branch-offset width
//   PC_RESET     : PC value after reset
//   IR_RESET     : instruction register value after reset
//   dec_flags_t  : decoder outputs captured in EXEC and used in WB
package cpu_seq_pkg;

  localparam int         PC_WIDTH_DEF = 8;
  localparam int         PC_RESET     = 0;
  localparam logic [7:0] IR_RESET     = 8'h00;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_HALT,
    S_ERR
  } seq_state_t;

  typedef struct packed {
    logic regwrite;
    logic cbwrite;
    logic branchf;
    logic branchb;
  } dec_flags_t;

endpackage

// File: rtl/seq_wait_timer.sv
// MEM-state timeout counter.
//   clock_i, reset_n_i : clock, asynchronous active-low reset
//   clear_i            : load LOAD_VAL-1 (issued on the way into MEM)
//   enable_i           : count down one step (a MEM cycle without ack)
//   expired_o          : count has reached zero
// After a clear, expired_o rises in the LOAD_VAL-th counted cycle, so the
// owner sees exactly LOAD_VAL MEM cycles before giving up.
module seq_wait_timer #(
  parameter int LOAD_VAL = 15
) (
  input  logic clock_i,
  input  logic reset_n_i,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  logic [7:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = 8'(LOAD_VAL - 1);
    end else if (enable_i && (count_q != 8'd0)) begin
      count_d = count_q - 8'd1;
    end
  end

  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      count_q <= 8'd0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired_o = (count_q == 8'd0);

endmodule

// File: rtl/instr_sequencer.sv
// Multi-cycle sequencer for the 8-bit core: owns the PC and the instruction
// register, steps FETCH -> DECODE -> EXEC -> [MEM] -> WB, and computes the
// next PC (sequential, forward or backward branch, modulo 2^PC_WIDTH).
//
// Ports:
//   clock_i, reset_n_i           : clock, asynchronous active-low reset
//   start_i, start_pc_i          : start pulse and initial PC (IDLE only)
//   imem_req_o/valid_i/rdata_i   : instruction fetch handshake
//   pc_o, instruction_o          : current PC, instruction register
//   decode_en_o                  : decoder sampling cycle
//   memread_i .. done_i          : decoder outputs, sampled in EXEC
//   branch_offset_i              : unsigned branch distance
//   dmem_req_o, dmem_ack_i       : data-memory handshake
//   reg_we_o, cb_we_o            : write enables, pulsed in WB
//   busy_o, halted_o, error_o    : status
//
// Optional build macro SEQ_PERF_COUNT_EN adds instr_count_o[15:0], a
// saturating count of completed (WB) instructions.
//
// Every output is a decode of registered state, so there is no
// combinational path from any input to any output.
module instr_sequencer
  import cpu_seq_pkg::*;
#(
  parameter int PC_WIDTH     = PC_WIDTH_DEF,
  parameter int MEM_WAIT_MAX = 15
) (
  input  logic                clock_i,
  input  logic                reset_n_i,
  input  logic                start_i,
  input  logic [PC_WIDTH-1:0] start_pc_i,
  output logic                imem_req_o,
  input  logic                imem_valid_i,
  input  logic [7:0]          imem_rdata_i,
  output logic [PC_WIDTH-1:0] pc_o,
  output logic [7:0]          instruction_o,
  output logic                decode_en_o,
  input  logic                memread_i,
  input  logic                memwrite_i,
  input  logic                regwrite_i,
  input  logic                cbwrite_i,
  input  logic                branchf_i,
  input  logic                branchb_i,
  input  logic                done_i,
  input  logic [PC_WIDTH-1:0] branch_offset_i,
  output logic                dmem_req_o,
  input  logic                dmem_ack_i,
  output logic                reg_we_o,
  output logic                cb_we_o,
  output logic                busy_o,
  output logic                halted_o,
  output logic                error_o
`ifdef SEQ_PERF_COUNT_EN
  ,
  output logic [15:0]         instr_count_o
`endif
);

  seq_state_t          state_q, state_d;
  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic [7:0]          ir_q, ir_d;
  dec_flags_t          flags_q, flags_d;
  logic                timer_clear, timer_en, timer_expired;

  seq_wait_timer #(
    .LOAD_VAL (MEM_WAIT_MAX)
  ) u_wait_timer (
    .clock_i   (clock_i),
    .reset_n_i (reset_n_i),
    .clear_i   (timer_clear),
    .enable_i  (timer_en),
    .expired_o (timer_expired)
  );

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    ir_d        = ir_q;
    flags_d     = flags_q;
    timer_clear = 1'b0;
    timer_en    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          pc_d    = start_pc_i;
          state_d = S_FETCH;
        end
      end
      S_FETCH: begin
        if (imem_valid_i) begin
          ir_d    = imem_rdata_i;
          state_d = S_DECODE;
        end
      end
      S_DECODE: state_d = S_EXEC;
      S_EXEC: begin
        // Decoder outputs are captured here so WB drives its enables from
        // flops rather than from live decoder inputs.
        flags_d.regwrite = regwrite_i;
        flags_d.cbwrite  = cbwrite_i;
        flags_d.branchf  = branchf_i;
        flags_d.branchb  = branchb_i;
        if (done_i) begin
          state_d = S_HALT;
        end else if (memread_i || memwrite_i) begin
          timer_clear = 1'b1;
          state_d     = S_MEM;
        end else begin
          state_d = S_WB;
        end
      end
      S_MEM: begin
        // Ack is tested first so it wins over a timeout in the same cycle.
        if (dmem_ack_i) begin
          state_d = S_WB;
        end else if (timer_expired) begin
          state_d = S_ERR;
        end else begin
          timer_en = 1'b1;
        end
      end
      S_WB: begin
        if (flags_q.branchf) begin
          pc_d = pc_q + branch_offset_i;
        end else if (flags_q.branchb) begin
          pc_d = pc_q - branch_offset_i;
        end else begin
          pc_d = pc_q + PC_WIDTH'(1);
        end
        state_d = S_FETCH;
      end
      S_HALT, S_ERR: state_d = state_q;
      default:       state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= S_IDLE;
      pc_q    <= PC_WIDTH'(PC_RESET);
      ir_q    <= IR_RESET;
      flags_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      flags_q <= flags_d;
    end
  end

  assign pc_o          = pc_q;
  assign instruction_o = ir_q;
  assign imem_req_o    = (state_q == S_FETCH);
  assign decode_en_o   = (state_q == S_DECODE);
  assign dmem_req_o    = (state_q == S_MEM);
  assign reg_we_o      = (state_q == S_WB) && flags_q.regwrite;
  assign cb_we_o       = (state_q == S_WB) && flags_q.cbwrite;
  assign halted_o      = (state_q == S_HALT);
  assign error_o       = (state_q == S_ERR);
  assign busy_o        = (state_q != S_IDLE) && (state_q != S_HALT) &&
                         (state_q != S_ERR);

`ifdef SEQ_PERF_COUNT_EN
  logic [15:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if ((state_q == S_IDLE) && start_i) begin
      count_d = 16'd0;
    end else if ((state_q == S_WB) && (count_q != 16'hFFFF)) begin
      count_d = count_q + 16'd1;
    end
  end

  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      count_q <= 16'd0;
    end else begin
      count_q <= count_d;
    end
  end

  assign instr_count_o = count_q;
`else
  // Performance counter not built.
`endif

endmodule

// File: tb/tb_instr_sequencer.sv
module tb_instr_sequencer;

  localparam int MAX = 15;

  logic       clk = 1'b0;
  logic       reset_n_i = 1'b0;
  logic       start_i = 1'b0;
  logic [7:0] start_pc_i = 8'h00;
  logic       imem_req_o;
  logic       imem_valid_i = 1'b0;
  logic [7:0] imem_rdata_i = 8'h00;
  logic [7:0] pc_o;
  logic [7:0] instruction_o;
  logic       decode_en_o;
  logic       memread_i = 1'b0, memwrite_i = 1'b0, regwrite_i = 1'b0;
  logic       cbwrite_i = 1'b0, branchf_i = 1'b0, branchb_i = 1'b0;
  logic       done_i = 1'b0;
  logic [7:0] branch_offset_i = 8'h00;
  logic       dmem_req_o;
  logic       dmem_ack_i = 1'b0;
  logic       reg_we_o, cb_we_o, busy_o, halted_o, error_o;
`ifdef SEQ_PERF_COUNT_EN
  logic [15:0] instr_count_o;
`endif

  instr_sequencer #(
    .PC_WIDTH     (8),
    .MEM_WAIT_MAX (MAX)
  ) dut (
    .clock_i         (clk),
    .reset_n_i       (reset_n_i),
    .start_i         (start_i),
    .start_pc_i      (start_pc_i),
    .imem_req_o      (imem_req_o),
    .imem_valid_i    (imem_valid_i),
    .imem_rdata_i    (imem_rdata_i),
    .pc_o            (pc_o),
    .instruction_o   (instruction_o),
    .decode_en_o     (decode_en_o),
    .memread_i       (memread_i),
    .memwrite_i      (memwrite_i),
    .regwrite_i      (regwrite_i),
    .cbwrite_i       (cbwrite_i),
    .branchf_i       (branchf_i),
    .branchb_i       (branchb_i),
    .done_i          (done_i),
    .branch_offset_i (branch_offset_i),
    .dmem_req_o      (dmem_req_o),
    .dmem_ack_i      (dmem_ack_i),
    .reg_we_o        (reg_we_o),
    .cb_we_o         (cb_we_o),
    .busy_o          (busy_o),
    .halted_o        (halted_o),
    .error_o         (error_o)
`ifdef SEQ_PERF_COUNT_EN
    ,
    .instr_count_o   (instr_count_o)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference state: architectural PC and completed-instruction count.
  logic [7:0] m_pc;
  int         m_cnt;

  // Output bit order: imem_req, decode_en, dmem_req, reg_we, cb_we,
  // busy, halted, error.
  localparam logic [7:0] O_IDLE   = 8'b0000_0000;
  localparam logic [7:0] O_FETCH  = 8'b1000_0100;
  localparam logic [7:0] O_DECODE = 8'b0100_0100;
  localparam logic [7:0] O_EXEC   = 8'b0000_0100;
  localparam logic [7:0] O_MEM    = 8'b0010_0100;
  localparam logic [7:0] O_HALT   = 8'b0000_0010;
  localparam logic [7:0] O_ERR    = 8'b0000_0001;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] outs();
    return {imem_req_o, decode_en_o, dmem_req_o, reg_we_o, cb_we_o,
            busy_o, halted_o, error_o};
  endfunction

  // Random values on every input the sequencer must ignore this cycle.
  task automatic rand_in();
    start_i      = 1'($urandom);
    start_pc_i   = 8'($urandom);
    imem_valid_i = 1'($urandom);
    imem_rdata_i = 8'($urandom);
    {memread_i, memwrite_i, regwrite_i, cbwrite_i,
     branchf_i, branchb_i, done_i} = 7'($urandom);
    dmem_ack_i   = 1'($urandom);
  endtask

  // One clock: inputs already driven, check on the falling edge, then
  // advance to just after the next rising edge.
  task automatic cyc(input string tag, input logic [7:0] exp_o);
    @(negedge clk);
    chk(tag, 32'(outs()), 32'(exp_o));
    chk({tag, "_pc"}, 32'(pc_o), 32'(m_pc));
`ifdef SEQ_PERF_COUNT_EN
    chk({tag, "_cnt"}, 32'(instr_count_o), 32'(m_cnt));
`endif
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n_i = 1'b0;
    start_i = 1'b0; imem_valid_i = 1'b0; dmem_ack_i = 1'b0;
    {memread_i, memwrite_i, regwrite_i, cbwrite_i,
     branchf_i, branchb_i, done_i} = 7'd0;
    #1;
    @(posedge clk);
    @(negedge clk);
    chk("rst_outs", 32'(outs()), 32'(O_IDLE));
    chk("rst_pc", 32'(pc_o), 32'h0);
    chk("rst_ir", 32'(instruction_o), 32'h0);
`ifdef SEQ_PERF_COUNT_EN
    chk("rst_cnt", 32'(instr_count_o), 32'h0);
`endif
    reset_n_i = 1'b1;
    @(posedge clk);
    #1;
    m_pc = 8'h00;
    m_cnt = 0;
  endtask

  task automatic do_start(input logic [7:0] pc);
    rand_in();
    start_i = 1'b0;
    cyc("idle", O_IDLE);
    rand_in();
    start_i = 1'b1;
    start_pc_i = pc;
    cyc("idle_start", O_IDLE);
    m_pc = pc;
    m_cnt = 0;
  endtask

  // Runs one instruction through the expected cycle schedule.
  // fwait: FETCH cycles before imem_valid_i; await: MEM cycle carrying the
  // ack (0 = never). result: 0 completed, 1 halted, 2 error.
  task automatic run_instr(input logic [7:0] ins, input bit rw, input bit cw,
                           input bit bf, input bit bb, input bit dn,
                           input bit mr, input bit mw, input logic [7:0] off,
                           input int fwait, input int await, output int result);
    bit acked;
    branch_offset_i = off;
    for (int i = 0; i <= fwait; i++) begin
      rand_in();
      imem_valid_i = (i == fwait);
      if (i == fwait) imem_rdata_i = ins;
      cyc("fetch", O_FETCH);
    end
    rand_in();
    cyc("decode", O_DECODE);
    chk("ir", 32'(instruction_o), 32'(ins));
    rand_in();
    {regwrite_i, cbwrite_i, branchf_i, branchb_i, done_i, memread_i, memwrite_i} =
      {rw, cw, bf, bb, dn, mr, mw};
    cyc("exec", O_EXEC);
    if (dn) begin
      rand_in();
      cyc("halt", O_HALT);
      rand_in();
      start_i = 1'b1;
      cyc("halt_hold", O_HALT);
      result = 1;
      return;
    end
    if (mr || mw) begin
      acked = 1'b0;
      for (int k = 1; k <= MAX; k++) begin
        rand_in();
        dmem_ack_i = (k == await);
        cyc("mem", O_MEM);
        if (k == await) begin
          acked = 1'b1;
          break;
        end
      end
      if (!acked) begin
        rand_in();
        cyc("err", O_ERR);
        result = 2;
        return;
      end
    end
    rand_in();
    cyc("wb", {3'b000, rw, cw, 3'b100});
    if (bf)      m_pc = m_pc + off;
    else if (bb) m_pc = m_pc - off;
    else         m_pc = m_pc + 8'd1;
    if (m_cnt < 65535) m_cnt++;
    result = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int res;
    do_reset();

    // Simple register-write instruction, then PC+1 at the next fetch.
    do_start(8'h10);
    run_instr(8'h41, 1, 0, 0, 0, 0, 0, 0, 8'h33, 0, 0, res);
    chk("t1_res", 32'(res), 32'd0);
    chk("t1_pc", 32'(pc_o), 32'h11);
    rand_in(); imem_valid_i = 1'b0;
    cyc("t1_fetch", O_FETCH);

    // Forward branch wraps.
    do_reset();
    do_start(8'hF8);
    run_instr(8'h80, 0, 1, 1, 0, 0, 0, 0, 8'h0A, 1, 0, res);
    chk("bf_wrap", 32'(pc_o), 32'h02);

    // Backward branch wraps, then both flags: forward wins.
    do_reset();
    do_start(8'h05);
    run_instr(8'h90, 0, 0, 0, 1, 0, 0, 0, 8'h07, 2, 0, res);
    chk("bb_wrap", 32'(pc_o), 32'hFE);
    run_instr(8'h91, 1, 1, 1, 1, 0, 0, 0, 8'h03, 0, 0, res);
    chk("both_fwd", 32'(pc_o), 32'h01);

    // Load with ack on the third MEM cycle, then ack exactly at the limit.
    do_reset();
    do_start(8'h30);
    run_instr(8'h20, 1, 0, 0, 0, 0, 1, 0, 8'h00, 0, 3, res);
    chk("ld_res", 32'(res), 32'd0);
    chk("ld_pc", 32'(pc_o), 32'h31);
    run_instr(8'h21, 0, 0, 0, 0, 0, 0, 1, 8'h00, 0, MAX, res);
    chk("ack_at_max", 32'(res), 32'd0);

    // Store never acknowledged: error, start ignored afterwards.
    run_instr(8'h22, 0, 0, 0, 0, 0, 0, 1, 8'h00, 0, 0, res);
    chk("st_timeout", 32'(res), 32'd2);
    for (int i = 0; i < 3; i++) begin
      rand_in();
      start_i = 1'b1;
      cyc("err_hold", O_ERR);
    end

    // Halt with write flags set: no write pulse.
    do_reset();
    do_start(8'h40);
    run_instr(8'hF0, 1, 1, 0, 0, 1, 1, 1, 8'h00, 0, 0, res);
    chk("halt_res", 32'(res), 32'd1);

    // Reset asserted mid-FETCH clears outputs without a clock edge.
    do_reset();
    do_start(8'h50);
    rand_in(); imem_valid_i = 1'b0;
    @(negedge clk);
    chk("pre_rst", 32'(outs()), 32'(O_FETCH));
    #1 reset_n_i = 1'b0;
    #1;
    chk("async_outs", 32'(outs()), 32'(O_IDLE));
    chk("async_pc", 32'(pc_o), 32'h0);
    chk("async_ir", 32'(instruction_o), 32'h0);
    @(posedge clk);
    #1;
    chk("async_hold", 32'(outs()), 32'(O_IDLE));
    reset_n_i = 1'b1;
    @(posedge clk);
    #1;
    m_pc = 8'h00;
    m_cnt = 0;

    // Three instructions then halt.
    do_start(8'h00);
    run_instr(8'h01, 1, 0, 0, 0, 0, 0, 0, 8'h00, 0, 0, res);
    run_instr(8'h02, 0, 1, 0, 0, 0, 1, 0, 8'h00, 1, 2, res);
    run_instr(8'h03, 0, 0, 1, 0, 0, 0, 0, 8'h04, 0, 0, res);
    run_instr(8'hFF, 0, 0, 0, 0, 1, 0, 0, 8'h00, 0, 0, res);
    chk("three_pc", 32'(pc_o), 32'h06);
`ifdef SEQ_PERF_COUNT_EN
    chk("perf_cnt3", 32'(instr_count_o), 32'd3);
`endif

    // Randomized instruction stream.
    do_reset();
    do_start(8'($urandom));
    for (int n = 0; n < 80; n++) begin
      bit mr, mw, dn;
      int aw;
      dn = ($urandom_range(0, 19) == 0);
      mr = ($urandom_range(0, 2) == 0);
      mw = !mr && ($urandom_range(0, 3) == 0);
      aw = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, MAX);
      run_instr(8'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                1'($urandom), dn, mr, mw, 8'($urandom),
                $urandom_range(0, 3), aw, res);
      if (res != 0) begin
        do_reset();
        do_start(8'($urandom));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/instr_sequencer.md
# instr_sequencer

Multi-cycle sequencer for the 8-bit processor core: fetches an instruction into its instruction register, holds the decoder through its one-cycle registered decode, and issues the data-memory handshake and register-file / CB write enables in their own cycles. It also computes the next PC, forward or backward on a taken branch. It sits between instruction memory, the instruction decoder and the datapath, and owns the PC.

## Interface
- PC_WIDTH, 8, PC and branch-offset width
- MEM_WAIT_MAX, 15, max MEM-state cycles without dmem_ack_i before error (1..255)

- clock_i  in  1  single clock, rising edge
- reset_n_i  in  1  asynchronous, active-low reset
- start_i  in  1  start pulse; honoured only in IDLE
- start_pc_i  in  PC_WIDTH  initial PC loaded on start
- imem_req_o  out  1  instruction fetch request
- imem_valid_i  in  1  fetch data valid this cycle
- imem_rdata_i  in  8  fetched instruction
- pc_o  out  PC_WIDTH  current PC
- instruction_o  out  8  instruction register to decoder
- decode_en_o  out  1  decoder sampling cycle
- memread_i, memwrite_i, regwrite_i, cbwrite_i, branchf_i, branchb_i, done_i  in  1 each  decoder outputs
- branch_offset_i  in  PC_WIDTH  unsigned branch distance from register file
- dmem_req_o  out  1  data-memory request
- dmem_ack_i  in  1  data-memory completion
- reg_we_o  out  1  gated register-file write
- cb_we_o  out  1  gated compare-bit write
- busy_o  out  1  not in IDLE/HALT/ERR
- halted_o  out  1  HALT state
- error_o  out  1  ERR state

## Operation
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT, ERR.
- IDLE: on start_i, load pc from start_pc_i and go to FETCH.
- FETCH: imem_req_o=1. On imem_valid_i, capture imem_rdata_i into the IR and go to DECODE. There is no timeout.
- DECODE: decode_en_o=1 for exactly one cycle, then go to EXEC.
- EXEC: decoder outputs are sampled here and only here.
  - done_i goes to HALT.
  - Otherwise, memread_i|memwrite_i goes to MEM.
  - Otherwise, go to WB.
- MEM: dmem_req_o=1 until the dmem_ack_i cycle (inclusive), then go to WB.
  - Wait counter counts cycles without ack; reaching MEM_WAIT_MAX goes to ERR.
  - Ack on the same cycle as the limit: the ack wins.
- WB: one cycle. reg_we_o=regwrite_i and cb_we_o=cbwrite_i.
  - Next PC: branchf_i gives pc+offset; else branchb_i gives pc-offset; else pc+1.
  - Both branch flags set: forward wins.
  - All PC arithmetic is modulo 2^PC_WIDTH (wraps silently).
  - Then go to FETCH.
- HALT and ERR are terminal until reset. start_i is ignored there and in every non-IDLE state.

## Timing
- Reset (async assert, sync deassert handled upstream):
  - state=IDLE, pc_o=0, instruction_o=0, wait counter=0.
  - All single-bit outputs are 0.
- All outputs are registered or decoded from the registered state only; there are no combinational paths from inputs to outputs.
- Non-memory instruction with imem_valid_i on the first FETCH cycle: 4 cycles (FETCH, DECODE, EXEC, WB).
- Memory instruction: 4 + N cycles, where N≥1 is the number of MEM cycles up to and including the ack.
- pc_o updates on the clock edge leaving WB. The next FETCH presents the new PC.
- Reset asserted mid-instruction aborts immediately; no write enable may pulse afterwards.

## Configuration
- SEQ_PERF_COUNT_EN defined:
  - Adds output instr_count_o [15:0].
  - Increments on every WB cycle and saturates at 16'hFFFF.
  - Cleared by reset and by start_i in IDLE.
- SEQ_PERF_COUNT_EN undefined: the port and counter are absent; all other behaviour is identical.

## Structure
- Shared package cpu_seq_pkg:
  - state enum seq_state_t.
  - PC_WIDTH default.
  - reset values of the PC and IR.
- Sub-module seq_wait_timer:
  - Loadable down-counter used for the MEM timeout.
  - Inputs: clear, enable.
  - Output: expired.

## Test plan
- Reset then start_i with start_pc_i=8'h10, imem_valid_i immediate, instruction 8'h41 (regwrite=1) -> reg_we_o pulses once in cycle 4; pc_o=8'h11 at the next FETCH.
- Branch-forward with pc=8'hF8, offset=8'h0A -> pc_o=8'h02 (wrap). Branch-backward with pc=8'h05, offset=8'h07 -> pc_o=8'hFE.
- Load with dmem_ack_i delayed 3 cycles -> dmem_req_o high 3 cycles, reg_we_o one cycle later, total 7 cycles.
- Store with no ack and MEM_WAIT_MAX=15 -> error_o=1 after 15 MEM cycles; later start_i is ignored.
- done_i in EXEC -> halted_o=1, busy_o=0, no reg_we_o/cb_we_o pulse; asserting reset_n_i low mid-FETCH of another run -> all outputs 0 asynchronously.
- With SEQ_PERF_COUNT_EN: 3 instructions then halt -> instr_count_o=3.
